wid_wide_packer: RTL and testbench

Upstream feeder for the 512-bit wide-register pipeline: gathers narrow input beats (default 64-bit) into one full-width word (default 512-bit) and presents it on a valid/ready output. Supports early word closure on a packet-end marker, with zero-padding of the unused lanes. Sustains one input beat per cycle while the downstream consumer keeps up.

---
 rtl/wid_pkg.sv | 12 +
 rtl/wid_wide_packer.sv | 157 +++++++++++++++
 tb/tb_wid_wide_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wid_pkg.sv
// Shared constants and state type for the wide-register packer.
package wid_pkg;

   localparam int unsigned WID_IN_W  = 64;
   localparam int unsigned WID_OUT_W = 512;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } wid_pack_state_e;

endpackage

// File: rtl/wid_wide_packer.sv
// Packs IN_W-bit beats into OUT_W-bit words on a valid/ready output.
// Define WID_PACKER_FLUSH_EN to let in_last close a partial, zero-padded word.
module wid_wide_packer
   import wid_pkg::*;
#(
   parameter int unsigned IN_W    = WID_IN_W,
   parameter int unsigned OUT_W   = WID_OUT_W,
   localparam int unsigned BEATS  = OUT_W / IN_W,
   localparam int unsigned CNT_W  = $clog2(BEATS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic [CNT_W-1:0]   out_beats,
   output logic               out_last,
   output logic [15:0]        out_words
);

   localparam int unsigned IDX_W = $clog2(BEATS);

   wid_pack_state_e    state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [OUT_W-1:0]   acc_q, acc_d, acc_ins;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic [15:0]        out_words_q, out_words_d;
   logic               accept, done, out_free, out_fire, flush;

`ifdef WID_PACKER_FLUSH_EN
   logic [CNT_W-1:0]   out_beats_q, out_beats_d;
   logic               out_last_q, out_last_d;
   logic [CNT_W-1:0]   hold_beats_q, hold_beats_d;
   logic               hold_last_q, hold_last_d;
   logic [CNT_W-1:0]   beats_now;

   assign flush     = in_last;
   assign beats_now = CNT_W'(idx_q) + CNT_W'(1);
   assign out_beats = out_beats_q;
   assign out_last  = out_last_q;
`else
   logic               unused_in_last;

   assign flush          = 1'b0;
   assign unused_in_last = in_last;
   assign out_beats      = CNT_W'(BEATS);
   assign out_last       = 1'b0;
`endif

   assign in_ready  = (state_q == FILL);
   assign accept    = in_valid && in_ready;
   assign done      = accept && ((idx_q == IDX_W'(BEATS - 1)) || flush);
   assign out_free  = !out_valid_q || out_ready;
   assign out_fire  = out_valid_q && out_ready;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_words = out_words_q;

   // Accumulator with the incoming beat dropped into lane idx.
   always_comb begin
      acc_ins = acc_q;
      for (int k = 0; k < BEATS; k++) begin
         if (idx_q == IDX_W'(k)) acc_ins[k*IN_W +: IN_W] = in_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_words_d = out_words_q + 16'(out_fire);
`ifdef WID_PACKER_FLUSH_EN
      out_beats_d  = out_beats_q;
      out_last_d   = out_last_q;
      hold_beats_d = hold_beats_q;
      hold_last_d  = hold_last_q;
`endif
      unique case (state_q)
         FILL: begin
            if (accept && !done) begin
               acc_d = acc_ins;
               idx_d = idx_q + IDX_W'(1);
            end else if (done && out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_ins;
               idx_d       = '0;
`ifdef WID_PACKER_FLUSH_EN
               acc_d       = '0;
               out_beats_d = beats_now;
               out_last_d  = flush;
`endif
            end else if (done) begin
               // Output still occupied: park the finished word in the accumulator.
               acc_d   = acc_ins;
               state_d = STALL;
`ifdef WID_PACKER_FLUSH_EN
               hold_beats_d = beats_now;
               hold_last_d  = flush;
`endif
            end
         end
         STALL: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_q;
               idx_d       = '0;
               state_d     = FILL;
`ifdef WID_PACKER_FLUSH_EN
               acc_d       = '0;
               out_beats_d = hold_beats_q;
               out_last_d  = hold_last_q;
`endif
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         idx_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_words_q <= '0;
`ifdef WID_PACKER_FLUSH_EN
         out_beats_q  <= '0;
         out_last_q   <= 1'b0;
         hold_beats_q <= '0;
         hold_last_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_words_q <= out_words_d;
`ifdef WID_PACKER_FLUSH_EN
         out_beats_q  <= out_beats_d;
         out_last_q   <= out_last_d;
         hold_beats_q <= hold_beats_d;
         hold_last_q  <= hold_last_d;
`endif
      end
   end

endmodule

// File: tb/tb_wid_wide_packer.sv
// Scoreboard bench for wid_wide_packer; expectations follow WID_PACKER_FLUSH_EN.
module tb_wid_wide_packer;

   localparam int IN_W  = 64;
   localparam int OUT_W = 512;
   localparam int BEATS = 8;
   localparam int CNT_W = 4;
`ifdef WID_PACKER_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [CNT_W-1:0] beats;
      logic             last;
   } word_t;

   word_t sb[$];
   int    hs_cyc[$];
   int    n_checks  = 0;
   int    n_errors  = 0;
   int    cyc       = 0;
   int    stall_cnt = 0;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_last   = 1'b0;
   logic             out_ready = 1'b0;
   logic [IN_W-1:0]  in_data   = '0;
   logic             in_ready, out_valid, out_last;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] out_beats;
   logic [15:0]      out_words;

   logic [OUT_W-1:0] m_acc = '0;
   int               m_n   = 0;
   logic [OUT_W-1:0] w_exp;
   word_t            e;

   wid_wide_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_beats (out_beats),
      .out_last  (out_last),
      .out_words (out_words)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [OUT_W-1:0] act,
                      input logic [OUT_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat, wait (bounded) for in_ready, and update the reference model.
   task automatic send(input logic [IN_W-1:0] d, input logic l);
      int w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && w < 200) begin
         tick();
         w++;
      end
      stall_cnt += w;
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
      end else begin
         tick();
         m_acc[m_n*IN_W +: IN_W] = d;
         m_n++;
         if (m_n == BEATS || (FLUSH && l)) begin
            sb.push_back('{data: m_acc, beats: CNT_W'(m_n), last: FLUSH && l});
            m_acc = '0;
            m_n   = 0;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
         tick();
         w++;
      end
      chk("drain_pending", OUT_W'(sb.size()), '0);
      tick();
   endtask

   // Monitor: pop and compare on every output handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
               e = sb.pop_front();
               chk("word_data", out_data, e.data);
               chk("word_beats", OUT_W'(out_beats), OUT_W'(e.beats));
               chk("word_last", OUT_W'(out_last), OUT_W'(e.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rst_out_valid", OUT_W'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_beats", OUT_W'(out_beats), FLUSH ? '0 : OUT_W'(BEATS));
      chk("rst_out_last", OUT_W'(out_last), '0);
      chk("rst_out_words", OUT_W'(out_words), '0);
      chk("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));

      // Full word 0..7, out_valid one cycle after the last beat.
      out_ready = 1'b1;
      for (int k = 0; k < BEATS; k++) begin
         send(IN_W'(k), 1'b0);
         if (k == BEATS - 2) chk("t1_valid_early", OUT_W'(out_valid), '0);
      end
      chk("t1_valid_rise", OUT_W'(out_valid), OUT_W'(1));
      w_exp = '0;
      for (int k = 0; k < BEATS; k++) w_exp[k*IN_W +: IN_W] = IN_W'(k);
      chk("t1_data", out_data, w_exp);
      drain();
      chk("t1_words", OUT_W'(out_words), OUT_W'(1));

      // Short packet A,B,C closed by in_last; without flush the word is topped up.
      send(64'hA, 1'b0);
      send(64'hB, 1'b0);
      send(64'hC, 1'b1);
      if (m_n != 0) begin
         for (int k = 0; k < 5; k++) send(IN_W'(64'hD + k), 1'b0);
      end
      drain();
      chk("t2_words", OUT_W'(out_words), OUT_W'(2));

      // Backpressure: 16 beats with out_ready low.
      out_ready = 1'b0;
      for (int k = 0; k < 2 * BEATS; k++) send(IN_W'(32'h100 + k), 1'b0);
      chk("stall_in_ready", OUT_W'(in_ready), '0);
      chk("stall_out_valid", OUT_W'(out_valid), OUT_W'(1));
      w_exp = '0;
      for (int k = 0; k < BEATS; k++) w_exp[k*IN_W +: IN_W] = IN_W'(32'h100 + k);
      for (int r = 0; r < 3; r++) begin
         chk("stall_hold", out_data, w_exp);
         tick();
      end
      out_ready = 1'b1;
      drain();
      chk("stall_words", OUT_W'(out_words), OUT_W'(4));

      // 64 back-to-back beats: no stall, one word every 8 cycles.
      hs_cyc.delete();
      stall_cnt = 0;
      for (int k = 0; k < 8 * BEATS; k++) send(IN_W'(32'h300 + k), 1'b0);
      drain();
      chk("cont_no_stall", OUT_W'(stall_cnt), '0);
      chk("cont_count", OUT_W'(hs_cyc.size()), OUT_W'(8));
      for (int i = 1; i < hs_cyc.size(); i++) begin
         chk("cont_spacing", OUT_W'(hs_cyc[i] - hs_cyc[i-1]), OUT_W'(BEATS));
      end
      chk("cont_words", OUT_W'(out_words), OUT_W'(12));

      // Reset mid-word drops the partial accumulator.
      for (int k = 0; k < 5; k++) send(IN_W'(32'h400 + k), 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", OUT_W'(out_valid), '0);
      chk("mid_rst_data", out_data, '0);
      chk("mid_rst_words", OUT_W'(out_words), '0);
      chk("mid_rst_last", OUT_W'(out_last), '0);
      chk("mid_rst_beats", OUT_W'(out_beats), FLUSH ? '0 : OUT_W'(BEATS));
      m_acc = '0;
      m_n   = 0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < BEATS; k++) send(IN_W'(32'h500 + k), 1'b0);
      drain();
      chk("post_rst_words", OUT_W'(out_words), OUT_W'(1));

      // Word counter wrap from 0xFFFF.
      force dut.out_words_q = 16'hFFFF;
      tick();
      release dut.out_words_q;
      tick();
      chk("wrap_pre", OUT_W'(out_words), OUT_W'(16'hFFFF));
      for (int k = 0; k < BEATS; k++) send(IN_W'(32'h600 + k), 1'b0);
      drain();
      chk("wrap_words", OUT_W'(out_words), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
